// File: rtl/rng_pkg.sv
// rng_pkg: shared types and constants for the LFSR word scheduler.
package rng_pkg;
    typedef enum logic {IDLE, SERVE} state_t;
    localparam int LFSR_W      = 16;
    localparam int LFSR_PERIOD = 65535;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at/after ptr with wrap.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);
    logic [IW:0] w_s;
    always_comb begin
        w_s   = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Walk offsets from the far end so the closest request to ptr wins last.
        for (int k = N - 1; k >= 0; k--) begin
            w_s = {1'b0, i_ptr} + (IW+1)'(k);
            w_s = (w_s >= (IW+1)'(N)) ? w_s - (IW+1)'(N) : w_s;
            if (i_req[w_s[IW-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_s[IW-1:0];
            end
        end
        o_gnt = o_any ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/rng_sched.sv
// rng_sched: round-robin sharing of one LFSR stream, each word consumed once, epoch counting.
// Define RNG_SCHED_BURST_EN to allow up to BURST_LEN words per grant; otherwise one word per grant.
module rng_sched
    import rng_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4,
    parameter int PERIOD    = LFSR_PERIOD,
    parameter int EPOCH_W   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       hold_i,
    input  logic [LFSR_W-1:0]          lfsr_i,
    output logic                       lfsr_en_o,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [LFSR_W-1:0]          rnd_o,
    output logic                       rnd_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] rnd_id_o,
    output logic                       epoch_tick_o,
    output logic [EPOCH_W-1:0]         epoch_cnt_o
);
    localparam int IW = $clog2(NUM_REQ);

    state_t               r_state, w_next;
    logic [IW-1:0]        r_ptr, r_owner, w_idx, w_owner_inc;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [15:0]          r_word_cnt;
    logic                 w_any, w_start, w_deliver, w_release, w_last, w_end, w_wrap;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_onehot),
        .o_idx (w_idx),
        .o_any (w_any)
    );

`ifdef RNG_SCHED_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0] r_burst;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_burst <= '0;
        else        r_burst <= w_start ? '0 : w_deliver ? r_burst + BW'(1) : r_burst;
    end
    assign w_last = w_deliver && (r_burst == BW'(BURST_LEN - 1));
`else
    assign w_last = w_deliver;
`endif

    always_comb begin
        w_start     = (r_state == IDLE) && !hold_i && w_any;
        w_deliver   = (r_state == SERVE) && !hold_i && req_i[r_owner];
        w_release   = (r_state == SERVE) && !hold_i && !req_i[r_owner];
        w_end       = w_release || w_last;
        w_owner_inc = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
        w_wrap      = (r_word_cnt == 16'(PERIOD - 1));
        w_next      = w_start ? SERVE : w_end ? IDLE : r_state;
        lfsr_en_o   = w_deliver;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ptr        <= '0;
            r_owner      <= '0;
            r_word_cnt   <= '0;
            gnt_o        <= '0;
            rnd_o        <= '0;
            rnd_valid_o  <= 1'b0;
            rnd_id_o     <= '0;
            epoch_tick_o <= 1'b0;
            epoch_cnt_o  <= '0;
        end else begin
            rnd_valid_o  <= w_deliver;
            epoch_tick_o <= w_deliver && w_wrap;
            if (w_start) begin
                gnt_o   <= w_onehot;
                r_owner <= w_idx;
            end
            if (w_end) begin
                gnt_o <= '0;
                r_ptr <= w_owner_inc;
            end
            if (w_deliver) begin
                rnd_o      <= lfsr_i;
                rnd_id_o   <= r_owner;
                r_word_cnt <= w_wrap ? '0 : r_word_cnt + 16'd1;
                if (w_wrap) epoch_cnt_o <= epoch_cnt_o + EPOCH_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rng_sched.sv
// tb_rng_sched: directed steps with a scoreboard of expected (owner, word) pairs.
module tb_rng_sched;
    localparam int N   = 4;
    localparam int PER = 5;
`ifdef RNG_SCHED_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    typedef struct {
        logic [1:0]  id;
        logic [15:0] w;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  req_i = '0;
    logic        hold_i = 1'b0;
    logic [15:0] lfsr = 16'h0001;
    logic        lfsr_en_o;
    logic [3:0]  gnt_o;
    logic [15:0] rnd_o;
    logic        rnd_valid_o;
    logic [1:0]  rnd_id_o;
    logic        epoch_tick_o;
    logic [7:0]  epoch_cnt_o;

    exp_t        q[$];
    logic [15:0] gen = 16'h0001;
    int          checks = 0;
    int          failures = 0;
    int          exp_wc = 0;
    int          exp_ep = 0;
    int          n;

    rng_sched #(.NUM_REQ(N), .BURST_LEN(4), .PERIOD(PER), .EPOCH_W(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .hold_i       (hold_i),
        .lfsr_i       (lfsr),
        .lfsr_en_o    (lfsr_en_o),
        .gnt_o        (gnt_o),
        .rnd_o        (rnd_o),
        .rnd_valid_o  (rnd_valid_o),
        .rnd_id_o     (rnd_id_o),
        .epoch_tick_o (epoch_tick_o),
        .epoch_cnt_o  (epoch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk_i) if (lfsr_en_o) lfsr <= step(lfsr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input int cnt);
        repeat (cnt) begin
            q.push_back('{id, gen});
            gen = step(gen);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_q(input int lim, output int cyc);
        cyc = 0;
        while (q.size() != 0 && cyc < lim) begin
            tick();
            cyc++;
        end
        chk("drain", q.size(), 0);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            exp_wc = 0;
            exp_ep = 0;
        end else if (rnd_valid_o) begin
            chk("queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_o", rnd_o, e.w);
                chk("rnd_id_o", rnd_id_o, e.id);
            end
            exp_wc++;
            if (exp_wc == PER) begin
                exp_wc = 0;
                exp_ep = (exp_ep + 1) % 256;
            end
            chk("epoch_tick", epoch_tick_o, exp_wc == 0);
            chk("epoch_cnt", epoch_cnt_o, exp_ep);
        end else begin
            chk("tick_idle", epoch_tick_o, 0);
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rnd", rnd_o, 0);
        chk("rst_valid", rnd_valid_o, 0);
        chk("rst_id", rnd_id_o, 0);
        chk("rst_tick", epoch_tick_o, 0);
        chk("rst_epoch", epoch_cnt_o, 0);
        chk("rst_lfsr_en", lfsr_en_o, 0);

        rst_i = 1'b1;
        req_i = 4'b0001;
        push(0, BL);
        tick();
        chk("gnt_first", gnt_o, 4'b0001);
        chk("valid_latency", rnd_valid_o, 0);
        chk("lfsr_en_serve", lfsr_en_o, 1);
        repeat (BL) tick();
        chk("gnt_bubble", gnt_o, 0);
        tick();
        chk("gnt_regrant", gnt_o, 4'b0001);
        chk("valid_regrant", rnd_valid_o, 0);
        req_i = 4'b0000;
        #1;
        chk("lfsr_en_drop", lfsr_en_o, 0);
        tick();
        chk("gnt_release", gnt_o, 0);
        chk("valid_release", rnd_valid_o, 0);
        chk("lfsr_no_step", lfsr, gen);
        wait_q(4, n);

        req_i = 4'b1111;
        push(1, BL); push(2, BL); push(3, BL); push(0, BL); push(1, BL);
        wait_q(100, n);
        chk("rr_cycles", n, 5 * (BL + 1));
        req_i = 4'b0000;
        tick();

        req_i = 4'b0001;
        push(0, BL);
        tick();
        chk("gnt_hold", gnt_o, 4'b0001);
        hold_i = 1'b1;
        #1;
        chk("lfsr_en_hold", lfsr_en_o, 0);
        repeat (3) begin
            tick();
            chk("valid_hold", rnd_valid_o, 0);
            chk("gnt_held", gnt_o, 4'b0001);
            chk("lfsr_en_hold", lfsr_en_o, 0);
        end
        chk("hold_lfsr", lfsr, q[0].w);
        hold_i = 1'b0;
        wait_q(20, n);
        req_i = 4'b0000;
        tick();
        chk("epoch_cnt_mid", epoch_cnt_o, exp_ep);

        req_i = 4'b0001;
        if (BL > 1) push(0, 1);
        tick();
        if (BL > 1) tick();
        rst_i = 1'b0;
        #1;
        chk("arst_gnt", gnt_o, 0);
        chk("arst_valid", rnd_valid_o, 0);
        chk("arst_rnd", rnd_o, 0);
        chk("arst_epoch", epoch_cnt_o, 0);
        chk("arst_lfsr_en", lfsr_en_o, 0);
        tick();
        tick();
        rst_i = 1'b1;
        req_i = 4'b1111;
        push(0, BL);
        tick();
        chk("gnt_after_reset", gnt_o, 4'b0001);
        wait_q(20, n);
        req_i = 4'b0000;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
